// File: rtl/box_update_ctrl.sv
// box_update_ctrl: accumulates the bounding rectangle of motion pixels over one
// frame and, at each frame boundary, publishes the overlay box flag and edges.
// The published outputs hold steady for the whole following frame.
module box_update_ctrl #(
    parameter int H_DISP      = 1280,
    parameter int V_DISP      = 720,
    parameter int MIN_PIX     = 64,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_img_vsync,
    input  logic        pre_img_hsync,
    input  logic        pre_img_valid,
    input  logic        motion_bit,
    output logic        box_flag,
    output logic [10:0] top_edge,
    output logic [10:0] bottom_edge,
    output logic [10:0] left_edge,
    output logic [10:0] right_edge,
    output logic        frame_done
);

    localparam logic [10:0] H_LIM     = 11'(H_DISP);
    localparam logic [10:0] V_LIM     = 11'(V_DISP);
    localparam logic [19:0] MIN_LIM   = 20'(MIN_PIX);
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [19:0] PIX_MAX   = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        valid_q, valid_d;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [10:0] y_cnt_q, y_cnt_d;
    logic [10:0] min_x_q, min_x_d;
    logic [10:0] max_x_q, max_x_d;
    logic [10:0] min_y_q, min_y_d;
    logic [10:0] max_y_q, max_y_d;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        box_flag_q, box_flag_d;
    logic [10:0] top_q, top_d;
    logic [10:0] bottom_q, bottom_d;
    logic [10:0] left_q, left_d;
    logic [10:0] right_q, right_d;
    logic        frame_done_q, frame_done_d;

    logic        vs_rise;
    logic        valid_fall;
    logic        pix_hit;

    // Line sync carries no information this block needs; coordinates come from valid.
    logic        unused_hsync;
    assign unused_hsync = pre_img_hsync;

    // Next-state logic: edge detection, coordinate counters, accumulation and publish decision.
    always_comb begin
        state_d      = state_q;
        vsync_d      = pre_img_vsync;
        valid_d      = pre_img_valid;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        min_x_d      = min_x_q;
        max_x_d      = max_x_q;
        min_y_d      = min_y_q;
        max_y_d      = max_y_q;
        pix_cnt_d    = pix_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        box_flag_d   = box_flag_q;
        top_d        = top_q;
        bottom_d     = bottom_q;
        left_d       = left_q;
        right_d      = right_q;
        frame_done_d = 1'b0;

        vs_rise    = pre_img_vsync & ~vsync_q;
        valid_fall = ~pre_img_valid & valid_q;
        pix_hit    = pre_img_valid & motion_bit & (x_cnt_q < H_LIM) & (y_cnt_q < V_LIM);

        if (vs_rise) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else begin
            if (pre_img_valid) begin
                if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + 11'd1;
            end else if (valid_fall) begin
                x_cnt_d = '0;
            end
            if (valid_fall && (y_cnt_q != CNT_MAX)) y_cnt_d = y_cnt_q + 11'd1;
        end

        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    state_d   = ACCUM;
                    pix_cnt_d = '0;
                    min_x_d   = '0;
                    max_x_d   = '0;
                    min_y_d   = '0;
                    max_y_d   = '0;
                end
            end
            ACCUM: begin
                if (pix_hit) begin
                    if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 20'd1;
                    if (pix_cnt_q == '0) begin
                        min_x_d = x_cnt_q;
                        max_x_d = x_cnt_q;
                        min_y_d = y_cnt_q;
                        max_y_d = y_cnt_q;
                    end else begin
                        if (x_cnt_q < min_x_q) min_x_d = x_cnt_q;
                        if (x_cnt_q > max_x_q) max_x_d = x_cnt_q;
                        if (y_cnt_q < min_y_q) min_y_d = y_cnt_q;
                        if (y_cnt_q > max_y_q) max_y_d = y_cnt_q;
                    end
                end
                if (vs_rise) begin
                    state_d      = PUBLISH;
                    frame_done_d = 1'b1;
                end
            end
            PUBLISH: begin
                if (pix_cnt_q >= MIN_LIM) begin
                    left_d     = min_x_q;
                    right_d    = max_x_q;
                    top_d      = min_y_q;
                    bottom_d   = max_y_q;
                    box_flag_d = 1'b1;
                    hold_cnt_d = HOLD_INIT;
                end else if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else begin
                    box_flag_d = 1'b0;
                end
                pix_cnt_d = '0;
                min_x_d   = '0;
                max_x_d   = '0;
                min_y_d   = '0;
                max_y_d   = '0;
                state_d   = ACCUM;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset clearing everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            valid_q      <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            min_x_q      <= '0;
            max_x_q      <= '0;
            min_y_q      <= '0;
            max_y_q      <= '0;
            pix_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            box_flag_q   <= 1'b0;
            top_q        <= '0;
            bottom_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            valid_q      <= valid_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            min_x_q      <= min_x_d;
            max_x_q      <= max_x_d;
            min_y_q      <= min_y_d;
            max_y_q      <= max_y_d;
            pix_cnt_q    <= pix_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            box_flag_q   <= box_flag_d;
            top_q        <= top_d;
            bottom_q     <= bottom_d;
            left_q       <= left_d;
            right_q      <= right_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign box_flag    = box_flag_q;
    assign top_edge    = top_q;
    assign bottom_edge = bottom_q;
    assign left_edge   = left_q;
    assign right_edge  = right_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_box_update_ctrl.sv
// tb_box_update_ctrl: directed scenarios for the box overlay controller with
// hand-computed expected flag, edge and frame_done values.
module tb_box_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pre_img_vsync;
    logic        pre_img_hsync;
    logic        pre_img_valid;
    logic        motion_bit;
    logic        box_flag;
    logic [10:0] top_edge;
    logic [10:0] bottom_edge;
    logic [10:0] left_edge;
    logic [10:0] right_edge;
    logic        frame_done;

    int checks_total;
    int checks_passed;

    box_update_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pre_img_vsync (pre_img_vsync),
        .pre_img_hsync (pre_img_hsync),
        .pre_img_valid (pre_img_valid),
        .motion_bit    (motion_bit),
        .box_flag      (box_flag),
        .top_edge      (top_edge),
        .bottom_edge   (bottom_edge),
        .left_edge     (left_edge),
        .right_edge    (right_edge),
        .frame_done    (frame_done)
    );

    // 10 ns pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line of len valid pixels with motion on x in [mlo, mhi], then one idle cycle.
    task automatic send_line(input int len, input int mlo, input int mhi);
        for (int i = 0; i < len; i++) begin
            pre_img_valid = 1'b1;
            pre_img_hsync = 1'b1;
            motion_bit    = (i >= mlo) && (i <= mhi);
            tick();
        end
        pre_img_valid = 1'b0;
        pre_img_hsync = 1'b0;
        motion_bit    = 1'b0;
        tick();
    endtask

    // n one-pixel lines without motion, used only to advance y.
    task automatic skip_lines(input int n);
        for (int i = 0; i < n; i++) send_line(1, 1, 0);
    endtask

    // Frame boundary; fd1 is frame_done in the cycle after the vsync rise, fd2 one
    // cycle later. With inject set, a motion pixel is presented in the PUBLISH cycle.
    task automatic frame_end(input bit inject, output logic fd1, output logic fd2);
        pre_img_vsync = 1'b1;
        tick();
        fd1 = frame_done;
        if (inject) begin
            pre_img_valid = 1'b1;
            motion_bit    = 1'b1;
        end
        tick();
        fd2 = frame_done;
        pre_img_valid = 1'b0;
        motion_bit    = 1'b0;
        pre_img_vsync = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic fd1, fd2;
        rst_n = 1'b0;
        repeat (3) tick();
        checks_total++;
        if ({box_flag, frame_done} !== 2'b00) $display("[TB] FAIL reset_flags got flag=%0b done=%0b want 0 0", box_flag, frame_done);
        else checks_passed++;
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== 44'd0)
            $display("[TB] FAIL reset_edges got %0d/%0d/%0d/%0d want 0/0/0/0", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
        rst_n = 1'b1;
        tick();
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({fd1, fd2} !== 2'b00) $display("[TB] FAIL reset_first_vsync got done=%0b%0b want 00", fd1, fd2);
        else checks_passed++;
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({fd1, fd2} !== 2'b10) $display("[TB] FAIL reset_second_vsync got done=%0b%0b want 10", fd1, fd2);
        else checks_passed++;
        checks_total++;
        if (box_flag !== 1'b0) $display("[TB] FAIL reset_empty_flag got %0b want 0", box_flag);
        else checks_passed++;
    endtask

    task automatic test_single_rect();
        logic fd1, fd2;
        skip_lines(50);
        for (int r = 0; r < 100; r++) send_line(200, 100, 199);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({fd1, fd2} !== 2'b10) $display("[TB] FAIL rect_done_pulse got %0b%0b want 10", fd1, fd2);
        else checks_passed++;
        checks_total++;
        if (box_flag !== 1'b1) $display("[TB] FAIL rect_flag got %0b want 1", box_flag);
        else checks_passed++;
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== {11'd100, 11'd199, 11'd50, 11'd149})
            $display("[TB] FAIL rect_edges got %0d/%0d/%0d/%0d want 100/199/50/149", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    task automatic test_below_threshold();
        logic fd1, fd2;
        skip_lines(10);
        send_line(73, 10, 72);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if (box_flag !== 1'b1) $display("[TB] FAIL below_flag got %0b want 1", box_flag);
        else checks_passed++;
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== {11'd100, 11'd199, 11'd50, 11'd149})
            $display("[TB] FAIL below_edges got %0d/%0d/%0d/%0d want 100/199/50/149", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    task automatic test_hold_expiry();
        logic fd1, fd2;
        skip_lines(5);
        send_line(84, 20, 83);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({box_flag, left_edge, right_edge, top_edge, bottom_edge} !== {1'b1, 11'd20, 11'd83, 11'd5, 11'd5})
            $display("[TB] FAIL min_pix_exact got flag=%0b %0d/%0d/%0d/%0d want 1 20/83/5/5", box_flag, left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
        for (int k = 1; k <= 9; k++) begin
            frame_end(1'b0, fd1, fd2);
            checks_total++;
            if (box_flag !== (k <= 8)) $display("[TB] FAIL hold_flag_%0d got %0b want %0b", k, box_flag, (k <= 8));
            else checks_passed++;
        end
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== {11'd20, 11'd83, 11'd5, 11'd5})
            $display("[TB] FAIL hold_edges got %0d/%0d/%0d/%0d want 20/83/5/5", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    task automatic test_range_boundary();
        logic fd1, fd2;
        send_line(1350, 1280, 1349);
        skip_lines(719);
        send_line(80, 0, 79);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({box_flag, left_edge, right_edge, top_edge, bottom_edge} !== {1'b0, 11'd20, 11'd83, 11'd5, 11'd5})
            $display("[TB] FAIL out_of_range got flag=%0b %0d/%0d/%0d/%0d want 0 20/83/5/5", box_flag, left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
        send_line(70, 0, 69);
        skip_lines(718);
        send_line(1290, 1279, 1289);
        send_line(80, 0, 79);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if (box_flag !== 1'b1) $display("[TB] FAIL range_flag got %0b want 1", box_flag);
        else checks_passed++;
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== {11'd0, 11'd1279, 11'd0, 11'd719})
            $display("[TB] FAIL range_edges got %0d/%0d/%0d/%0d want 0/1279/0/719", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    task automatic test_publish_drop();
        logic fd1, fd2;
        frame_end(1'b1, fd1, fd2);
        checks_total++;
        if ({box_flag, left_edge, right_edge} !== {1'b1, 11'd0, 11'd1279})
            $display("[TB] FAIL drop_hold got flag=%0b %0d/%0d want 1 0/1279", box_flag, left_edge, right_edge);
        else checks_passed++;
        send_line(74, 10, 73);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({left_edge, right_edge, top_edge, bottom_edge} !== {11'd10, 11'd73, 11'd1, 11'd1})
            $display("[TB] FAIL drop_edges got %0d/%0d/%0d/%0d want 10/73/1/1", left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        logic fd1, fd2;
        skip_lines(2);
        pre_img_valid = 1'b1;
        motion_bit    = 1'b1;
        rst_n         = 1'b0;
        repeat (3) tick();
        pre_img_valid = 1'b0;
        motion_bit    = 1'b0;
        checks_total++;
        if ({box_flag, frame_done, left_edge, right_edge, top_edge, bottom_edge} !== 46'd0)
            $display("[TB] FAIL midreset_outputs got flag=%0b done=%0b %0d/%0d/%0d/%0d want all 0", box_flag, frame_done, left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
        rst_n = 1'b1;
        tick();
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if ({fd1, fd2, box_flag} !== 3'b000) $display("[TB] FAIL midreset_arm got done=%0b%0b flag=%0b want 000", fd1, fd2, box_flag);
        else checks_passed++;
        send_line(80, 0, 79);
        frame_end(1'b0, fd1, fd2);
        checks_total++;
        if (fd1 !== 1'b1) $display("[TB] FAIL midreset_publish got done=%0b want 1", fd1);
        else checks_passed++;
        checks_total++;
        if ({box_flag, left_edge, right_edge, top_edge, bottom_edge} !== {1'b1, 11'd0, 11'd79, 11'd0, 11'd0})
            $display("[TB] FAIL midreset_edges got flag=%0b %0d/%0d/%0d/%0d want 1 0/79/0/0", box_flag, left_edge, right_edge, top_edge, bottom_edge);
        else checks_passed++;
    endtask

    // Scenario sequence; each scenario leaves the DUT in ACCUM for the next one.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n         = 1'b0;
        pre_img_vsync = 1'b0;
        pre_img_hsync = 1'b0;
        pre_img_valid = 1'b0;
        motion_bit    = 1'b0;
        #2;
        test_reset();
        test_single_rect();
        test_below_threshold();
        test_hold_expiry();
        test_range_boundary();
        test_publish_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
